// File: rtl/iq_sample_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : iq_sample_serializer_if
// Purpose  : Frame-load handshake bundle for iq_sample_serializer. A producer
//            offers a packed frame of p_depth 5-bit samples with load_valid.
//            The serializer accepts it when load_ready is high.
// Signals  : load_valid - producer offers a frame on load_data
//            load_data  - packed frame, sample k at bits [5k+4:5k]
//            load_ready - serializer shadow buffer is empty
// Modports : master (frame producer), slave (serializer)
// Revision : 1.0 - initial release
// ============================================================================
interface iq_sample_serializer_if #(
  parameter int p_depth = 10
);
  logic                   load_valid;
  logic                   load_ready;
  logic [5*p_depth-1:0]   load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface
`default_nettype wire

// File: rtl/iq_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module   : iq_sample_serializer
// Purpose  : Accepts frames of p_depth 5-bit samples over a valid/ready
//            handshake, buffers one further frame in a shadow register and
//            emits one sample per p_div-cycle sample period. A sample launches
//            on a tick, which is an enabled cycle with index == 0.
// Ports    : clk         - rising-edge clock
//            reset       - asynchronous active-low reset
//            enable      - run; when low the phase counter and FSM hold
//            load        - frame-load handshake (slave modport)
//            data_out    - current sample, held between launches
//            data_valid  - one-cycle pulse per new sample
//            index       - sample-period phase, 0..p_div-1
//            frame_start - pulses with data_valid for sample 0
//            frame_done  - pulses with data_valid for sample p_depth-1
//            underrun    - pulses when a frame ends with no frame buffered
// Revision : 1.0 - initial release
// ============================================================================
module iq_sample_serializer #(
  parameter int p_depth = 10,
  parameter int p_div   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  iq_sample_serializer_if.slave       load,
  output logic [4:0]                  data_out,
  output logic                        data_valid,
  output logic [2:0]                  index,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        underrun
);

  localparam int         c_width    = 5 * p_depth;
  localparam logic [2:0] c_idx_last = 3'(p_div - 1);
  localparam logic [3:0] c_cnt_init = 4'(p_depth - 1);

  generate
    if (p_depth < 2 || p_depth > 16) begin : g_bad_depth
      $error("iq_sample_serializer: p_depth must be in 2..16");
    end
    if (p_div < 2 || p_div > 8) begin : g_bad_div
      $error("iq_sample_serializer: p_div must be in 2..8");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           index_q, index_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [c_width-1:0]   shift_q, shift_d;
  logic [c_width-1:0]   shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;
  logic [4:0]           data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_start_q, frame_start_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underrun_q, underrun_d;

  logic                 tick;
  logic                 load_accept;
  logic                 start_frame;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    underrun_d    = 1'b0;
    start_frame   = 1'b0;

    tick        = enable & (index_q == 3'd0);
    load_accept = load.load_valid & ~shadow_full_q;

    if (enable) begin
      index_d = (index_q == c_idx_last) ? 3'd0 : index_q + 3'd1;
    end

    // The tick below looks only at shadow_full_q, so a frame accepted on a
    // tick cycle is picked up at the following tick. Accept and transfer are
    // mutually exclusive because they need opposite shadow_full_q values.
    if (load_accept) begin
      shadow_d      = load.load_data;
      shadow_full_d = 1'b1;
    end

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (shadow_full_q) begin
            start_frame = 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q != 4'd0) begin
            // shift_q holds the samples not yet launched, next one in [4:0]
            data_out_d   = shift_q[4:0];
            shift_d      = {5'd0, shift_q[c_width-1:5]};
            data_valid_d = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            frame_done_d = (cnt_q == 4'd1);
          end else if (shadow_full_q) begin
            start_frame = 1'b1;
          end else begin
            underrun_d = 1'b1;
            data_out_d = 5'd0;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Sample 0 goes straight out of the shadow; the remaining samples are
    // parked in the shift register already aligned for the next launch.
    if (start_frame) begin
      data_out_d    = shadow_q[4:0];
      shift_d       = {5'd0, shadow_q[c_width-1:5]};
      shadow_full_d = 1'b0;
      cnt_d         = c_cnt_init;
      data_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      state_d       = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      index_q       <= 3'd0;
      cnt_q         <= 4'd0;
      shift_q       <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      data_out_q    <= 5'd0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign load.load_ready = ~shadow_full_q;
  assign data_out        = data_out_q;
  assign data_valid      = data_valid_q;
  assign index           = index_q;
  assign frame_start     = frame_start_q;
  assign frame_done      = frame_done_q;
  assign underrun        = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_sample_serializer
// Purpose  : Self-checking bench for iq_sample_serializer. Two instances run
//            side by side: A with default parameters (10 samples, 8-cycle
//            period) and B with 2 samples and a 2-cycle period. A frame-level
//            reference model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_sample_serializer;

  localparam int c_dep_a = 10;
  localparam int c_div_a = 8;
  localparam int c_dep_b = 2;
  localparam int c_div_b = 2;

  logic clk;
  logic rst_n;
  logic en;

  iq_sample_serializer_if #(.p_depth(c_dep_a)) if_a ();
  iq_sample_serializer_if #(.p_depth(c_dep_b)) if_b ();

  logic [4:0] a_data, b_data;
  logic       a_valid, b_valid, a_start, b_start, a_done, b_done, a_under, b_under;
  logic [2:0] a_index, b_index;

  iq_sample_serializer #(.p_depth(c_dep_a), .p_div(c_div_a)) u_dut_a (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (en),
    .load        (if_a),
    .data_out    (a_data),
    .data_valid  (a_valid),
    .index       (a_index),
    .frame_start (a_start),
    .frame_done  (a_done),
    .underrun    (a_under)
  );

  iq_sample_serializer #(.p_depth(c_dep_b), .p_div(c_div_b)) u_dut_b (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (en),
    .load        (if_b),
    .data_out    (b_data),
    .data_valid  (b_valid),
    .index       (b_index),
    .frame_start (b_start),
    .frame_done  (b_done),
    .underrun    (b_under)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: counts enabled cycles to find ticks, keeps at most one
  // buffered frame and the frame being played out with the index of the next
  // sample to emit.
  // --------------------------------------------------------------------------
  int          m_en_cnt [2];
  bit          m_pend   [2];
  logic [79:0] m_pdata  [2];
  bit          m_active [2];
  int          m_pos    [2];
  logic [79:0] m_cur    [2];
  logic [4:0]  e_data   [2];
  bit          e_valid  [2];
  bit          e_start  [2];
  bit          e_done   [2];
  bit          e_under  [2];

  task automatic model_reset(input int k);
    m_en_cnt[k] = 0;
    m_pend[k]   = 0;
    m_pdata[k]  = '0;
    m_active[k] = 0;
    m_pos[k]    = 0;
    m_cur[k]    = '0;
    e_data[k]   = '0;
    e_valid[k]  = 0;
    e_start[k]  = 0;
    e_done[k]   = 0;
    e_under[k]  = 0;
  endtask

  task automatic model_step(input int k, input int dep, input int div,
                            input bit lv, input logic [79:0] ld);
    bit tick;
    bit acc;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    tick = en && ((m_en_cnt[k] % div) == 0);
    acc  = lv && !m_pend[k];
    e_valid[k] = 0;
    e_start[k] = 0;
    e_done[k]  = 0;
    e_under[k] = 0;
    if (tick) begin
      if (m_active[k] && m_pos[k] < dep) begin
        e_data[k]  = m_cur[k][5*m_pos[k] +: 5];
        e_valid[k] = 1;
        m_pos[k]++;
        e_done[k]  = (m_pos[k] == dep);
      end else if (m_pend[k]) begin
        m_cur[k]    = m_pdata[k];
        m_pend[k]   = 0;
        e_data[k]   = m_cur[k][4:0];
        e_valid[k]  = 1;
        e_start[k]  = 1;
        m_pos[k]    = 1;
        m_active[k] = 1;
      end else if (m_active[k]) begin
        e_under[k]  = 1;
        e_data[k]   = 5'd0;
        m_active[k] = 0;
      end
    end
    if (acc) begin
      m_pend[k]  = 1;
      m_pdata[k] = ld;
    end
    if (en) m_en_cnt[k]++;
  endtask

  task automatic compare_all();
    chk("A.data_out",    32'(a_data),              32'(e_data[0]));
    chk("A.data_valid",  32'(a_valid),             32'(e_valid[0]));
    chk("A.frame_start", 32'(a_start),             32'(e_start[0]));
    chk("A.frame_done",  32'(a_done),              32'(e_done[0]));
    chk("A.underrun",    32'(a_under),             32'(e_under[0]));
    chk("A.index",       32'(a_index),             32'(m_en_cnt[0] % c_div_a));
    chk("A.load_ready",  32'(if_a.load_ready),     32'(!m_pend[0]));
    chk("B.data_out",    32'(b_data),              32'(e_data[1]));
    chk("B.data_valid",  32'(b_valid),             32'(e_valid[1]));
    chk("B.frame_start", 32'(b_start),             32'(e_start[1]));
    chk("B.frame_done",  32'(b_done),              32'(e_done[1]));
    chk("B.underrun",    32'(b_under),             32'(e_under[1]));
    chk("B.index",       32'(b_index),             32'(m_en_cnt[1] % c_div_b));
    chk("B.load_ready",  32'(if_b.load_ready),     32'(!m_pend[1]));
  endtask

  logic [79:0] ld_a, ld_b;

  // One clock: the edge is modelled from the inputs stable before it, and the
  // DUT is compared on the following falling edge.
  task automatic step();
    @(posedge clk);
    model_step(0, c_dep_a, c_div_a, if_a.load_valid, ld_a);
    model_step(1, c_dep_b, c_div_b, if_b.load_valid, ld_b);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit lv_a, input bit lv_b, input bit enable);
    ld_a = {$urandom, $urandom, $urandom};
    ld_b = {$urandom, $urandom, $urandom};
    en              = enable;
    if_a.load_valid = lv_a;
    if_b.load_valid = lv_b;
    if_a.load_data  = ld_a[5*c_dep_a-1:0];
    if_b.load_data  = ld_b[5*c_dep_b-1:0];
  endtask

  int first_a;
  int first_b;
  bit hit;

  initial begin
    model_reset(0);
    model_reset(1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // Reset then a single frame 1..10 (B gets 1,2), both loaded at cycle 0.
    rst_n = 1'b1;
    en    = 1'b1;
    ld_a  = '0;
    for (int i = 0; i < c_dep_a; i++) ld_a[5*i +: 5] = 5'(i + 1);
    ld_b  = '0;
    ld_b[4:0] = 5'd1;
    ld_b[9:5] = 5'd2;
    if_a.load_valid = 1'b1;
    if_b.load_valid = 1'b1;
    if_a.load_data  = ld_a[5*c_dep_a-1:0];
    if_b.load_data  = ld_b[5*c_dep_b-1:0];
    first_a = -1;
    first_b = -1;
    for (int s = 0; s < 100; s++) begin
      step();
      if (a_valid && first_a < 0) first_a = s + 1;
      if (b_valid && first_b < 0) first_b = s + 1;
      if_a.load_valid = 1'b0;
      if_b.load_valid = 1'b0;
    end
    chk("A.first_sample_cycle", 32'(first_a), 32'd9);
    chk("B.first_sample_cycle", 32'(first_b), 32'd3);

    // Back-to-back frames with load_valid held high (backpressure).
    for (int s = 0; s < 400; s++) begin
      drive(1'b1, 1'b1, 1'b1);
      step();
    end

    // Fully random traffic including enable freezes.
    for (int s = 0; s < 2000; s++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) != 0);
      step();
    end

    // Reset mid-frame: wait for A's 6th sample with the shadow full.
    hit = 0;
    for (int s = 0; s < 400 && !hit; s++) begin
      drive(1'b1, 1'b1, 1'b1);
      step();
      hit = m_active[0] && (m_pos[0] == 6) && m_pend[0];
    end
    chk("reset_setup_reached", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 60; s++) begin
      drive(1'b0, 1'b0, $urandom_range(0, 3) != 0);
      step();
    end

    for (int s = 0; s < 500; s++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_sample_serializer.md
# iq_sample_serializer

Transmit-side counterpart of the IQ demodulator's sample delay line. It accepts a frame of `p_depth` 5-bit samples in parallel over a valid/ready handshake and buffers one further frame in a shadow register. It then emits the samples one at a time, one per sample period of `p_div` clock cycles, toward the modulator/DAC path. Sample periods are marked by the same 3-bit phase `index` that the receive path uses, so a sample launches when `index == 0`.

## Interface

Parameters:
- `p_depth`, default 10: samples per frame; legal range 2..16.
- `p_div`, default 8: clock cycles per sample period; legal range 2..8.

Ports:
- `clk`, in, 1: main clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run. When 0, the phase counter and the FSM hold.
- `load_valid`, in, 1: a frame is offered on `load_data`.
- `load_data`, in, 5*p_depth: packed frame. Sample k is at bits [5k+4:5k]. Sample 0 is emitted first.
- `load_ready`, out, 1: the shadow buffer is empty. Equals `~shadow_full`, decoded directly from a register.
- `data_out`, out, 5: current sample, held between launches.
- `data_valid`, out, 1: one-cycle pulse when a new sample appears on `data_out`.
- `index`, out, 3: current phase, 0..p_div-1.
- `frame_start`, out, 1: pulses with `data_valid` for sample 0 of a frame.
- `frame_done`, out, 1: pulses with `data_valid` for sample p_depth-1 of a frame.
- `underrun`, out, 1: one-cycle pulse when a frame ends and no next frame is buffered.

## Operation

Storage:
- Output shift register: `p_depth` x 5 bits.
- Remaining-sample counter: 0..p_depth-1.
- Shadow frame register plus a `shadow_full` flag.
- FSM: IDLE, RUN.

Handshake:
- A load is accepted when `load_valid & load_ready` is high on a rising edge.
- On accept, `load_data` is copied into the shadow register and `shadow_full` is set.
- The shadow register is never overwritten while full.

Phase counter and tick:
- When `enable = 1`, `index` increments modulo `p_div`. When `enable = 0` it holds.
- A tick is a cycle with `enable = 1` and `index == 0`. All FSM actions happen only on ticks.

FSM, on each tick:
- IDLE, `shadow_full = 1`: copy the shadow into the shift register and clear `shadow_full`. Drive sample 0 on `data_out` with `data_valid = 1` and `frame_start = 1`. Set the counter to p_depth-1. Go to RUN.
- IDLE, `shadow_full = 0`: no action.
- RUN, counter > 0: shift the register and drive the next sample with `data_valid`. Decrement the counter. If the new counter value is 0, assert `frame_done` with this sample.
- RUN, counter == 0, `shadow_full = 1`: start the next frame exactly as from IDLE. There is no gap sample. Stay in RUN.
- RUN, counter == 0, `shadow_full = 0`: pulse `underrun`, set `data_out` to 0, go to IDLE. `data_valid` stays 0.

Simultaneous events:
- A load accepted on the same cycle as a tick is not visible to that tick. The frame starts at the next tick.
- `enable = 0` mid-frame freezes the FSM, the counter, `index` and `data_out`. The frame resumes when `enable` returns.
- `load_valid` is ignored while `load_ready = 0`.
- Reset asserted mid-frame discards both the frame in progress and any buffered frame.

## Timing

Reset values:
- `data_out` = 0, `data_valid` = 0, `frame_start` = 0, `frame_done` = 0, `underrun` = 0, `index` = 0.
- `shadow_full` = 0, so `load_ready` = 1.
- FSM in IDLE.

Latency:
- All outputs are registered. An action on the tick at cycle t is visible at cycle t+1.
- A load accepted at cycle t drives `load_ready` low at t+1.
- A shadow transfer on the tick at cycle t drives `load_ready` high at t+1.

Output timing:
- `data_valid`, `frame_start` and `frame_done` each last exactly one cycle, and occur once per `p_div` enabled cycles.
- A frame of p_depth samples occupies p_depth consecutive sample periods.
- With the shadow register kept full, back-to-back frames have zero idle periods.

First tick after reset: the first cycle with `enable = 1` after `reset` is released is a tick, because `index` resets to 0.

## Test plan

- Reset then single frame: release `reset`; at cycle 0 assert `enable = 1` and load samples 0..9 = 1,2,...,10. Expected outputs:
  - First tick at cycle 0 sees an empty shadow and does nothing.
  - `data_out` shows 1 at cycle 9 with `frame_start`, then 2..10 every 8 cycles. `frame_done` accompanies the value 10.
  - One period later `underrun` pulses and `data_out` becomes 0.
- Back-to-back frames: load frame A (all 5) and then frame B (all 21) while A is running. The 10th sample (5, with `frame_done`) is followed 8 cycles later by 21 with `frame_start`, with no `underrun`.
- Backpressure: hold `load_valid = 1` with three frames queued. `load_ready` stays low from one cycle after the shadow accept until one cycle after the transfer tick. No frame is lost or duplicated.
- Enable freeze: deassert `enable` for 20 cycles after the 4th sample. `index`, `data_out` and the FSM hold. The 5th sample appears exactly 8 enabled cycles after the 4th.
- Reset mid-frame: assert `reset` during the 6th sample with the shadow full. All outputs return to their reset values immediately. After release, no further samples appear until a new load.
- Parameters `p_depth = 2`, `p_div = 2`: samples appear every 2 cycles, with `frame_start` and `frame_done` on consecutive samples. A load accepted on a tick cycle starts at the next tick.
